rom_blitter: RTL and testbench
==============================

ROM_BLITTER -- requirements
Module: rom_blitter

Interface
REQ-001 Parameter IMG_W, default 200, image width in pixels (ROM row length).
REQ-002 Parameter IMG_H, default 150, image height in rows; IMG_W*IMG_H SHALL be at most 32768.
REQ-003 Parameter FB_W, default 640, framebuffer width in pixels.
REQ-004 Parameter FB_H, default 480, framebuffer height in pixels.
REQ-005 Parameter KEY, default 12'hF0F, transparent colour (used only under REQ-030).
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request copy; sampled only in IDLE.
REQ-009 dst_x  in  10  framebuffer column of image top-left pixel.
REQ-010 dst_y  in  9  framebuffer row of image top-left pixel.
REQ-011 rom_addr  out  15  image ROM read address, row-major.
REQ-012 rom_data  in  12  ROM read data (RGB 4:4:4), valid one clk after rom_addr.
REQ-013 fb_we  out  1  framebuffer write strobe, one pixel per cycle.
REQ-014 fb_addr  out  19  framebuffer linear address, y*FB_W+x.
REQ-015 fb_data  out  12  pixel written.
REQ-016 busy  out  1  copy in progress.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH after address IMG_W*IMG_H-1 issued; FLUSH->DONE; DONE->IDLE unconditionally.
REQ-019 On IDLE->RUN, dst_x/dst_y SHALL be latched; later input changes have no effect on the running copy.
REQ-020 In RUN, rom_addr SHALL start at 0 and increment by 1 each cycle, with col/row counters wrapping col at IMG_W and advancing row.
REQ-021 Write pipeline SHALL delay address/valid by exactly one cycle so fb_data = rom_data for the address issued in the previous cycle.
REQ-022 fb_addr SHALL equal (dst_y+row)*FB_W + (dst_x+col) for the delayed col/row, computed with no truncation below 19 bits.
REQ-023 Clipping: pixels with dst_x+col >= FB_W or dst_y+row >= FB_H SHALL be read but not written (fb_we low).
REQ-024 Last pixel write SHALL occur in FLUSH; fb_we SHALL be low in IDLE and DONE.
REQ-025 busy SHALL be high in RUN, FLUSH, DONE and low in IDLE; done high only in DONE.
REQ-026 Latency: start sampled at edge k -> done high in cycle following edge k+IMG_W*IMG_H+1; total IMG_W*IMG_H+2 busy cycles.
REQ-027 start while busy SHALL be ignored (not queued); start held high through DONE SHALL begin a new copy on the IDLE cycle.
REQ-028 rom_addr SHALL hold 0 outside RUN.

Reset
REQ-029 rst high SHALL immediately force IDLE, rom_addr=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0, counters=0, including mid-copy; no partial write after rst deasserts.

Configuration
REQ-030 Macro TRANSPARENT_KEY_EN: when defined, a pixel whose rom_data equals KEY SHALL NOT be written (fb_we low that cycle, timing unchanged); when undefined, every non-clipped pixel is written and KEY is unused.

Verification
REQ-031 IMG_W=4, IMG_H=2, dst=(0,0), start 1 cycle -> 8 writes, fb_addr 0,1,2,3,640..643, fb_data matches ROM words 0..7, done 10 cycles after start edge.
REQ-032 dst=(638,479), IMG_W=4, IMG_H=2 -> only fb_addr 307198 and 307199 written; busy length still 10 cycles.
REQ-033 start pulsed again mid-RUN and dst changed -> no effect; single done; addresses use original dst.
REQ-034 rst asserted at 3rd RUN cycle -> fb_we/busy low same cycle; after release no writes until next start.
REQ-035 TRANSPARENT_KEY_EN defined, ROM word 2 = 12'hF0F -> no write for pixel 2, others written, done timing unchanged; undefined -> pixel 2 written with 12'hF0F.

Source files
------------

// File: rtl/rom_blitter.sv
// rom_blitter: copies an IMG_W x IMG_H ROM image into a framebuffer at (dst_x,dst_y), clipping at the frame edges.
// Define TRANSPARENT_KEY_EN to suppress writes of pixels whose colour equals KEY.
module rom_blitter #(
  parameter int IMG_W = 200,
  parameter int IMG_H = 150,
  parameter int FB_W = 640,
  parameter int FB_H = 480,
  parameter logic [11:0] KEY = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  dst_x,
  input  logic [8:0]  dst_y,
  output logic [14:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        busy,
  output logic        done
);
  localparam int N = IMG_W * IMG_H;
`ifdef TRANSPARENT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [14:0] col, row;
  logic wr;
  logic [31:0] px, py;
  logic last_col;
  always_comb begin
    px = 32'(x0) + 32'(col);
    py = 32'(y0) + 32'(row);
    last_col = col == 15'(IMG_W - 1);
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  // wr/fb_addr lag rom_addr by one cycle so they line up with the synchronous ROM output
  assign fb_we = wr && !(KEY_EN && rom_data == KEY);
  assign fb_data = wr ? rom_data : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      x0 <= '0;
      y0 <= '0;
      col <= '0;
      row <= '0;
      rom_addr <= '0;
      fb_addr <= '0;
      wr <= 1'b0;
    end else begin
      wr <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          x0 <= dst_x;
          y0 <= dst_y;
        end
        RUN: begin
          wr <= px < FB_W && py < FB_H;
          fb_addr <= 19'(py * FB_W + px);
          if (rom_addr == 15'(N - 1)) begin
            state <= FLUSH;
            rom_addr <= '0;
            col <= '0;
            row <= '0;
          end else begin
            rom_addr <= rom_addr + 15'd1;
            col <= last_col ? '0 : col + 15'd1;
            row <= last_col ? row + 15'd1 : row;
          end
        end
        FLUSH: state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rom_blitter.sv
// tb_rom_blitter: scoreboard bench for rom_blitter with a 4x2 image and a synchronous ROM model.
module tb_rom_blitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [9:0] dst_x = '0;
  logic [8:0] dst_y = '0;
  logic [14:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic busy, done;
  logic [11:0] rom [8];
  logic [30:0] q[$];
  int n_checks = 0;
  int n_fail = 0;

  rom_blitter #(.IMG_W(4), .IMG_H(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_x(dst_x), .dst_y(dst_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr[2:0]];

  // every observed write must match the oldest expected pixel
  always @(negedge clk) if (fb_we === 1'b1) begin
    logic [30:0] e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_write addr=%0d data=%h", fb_addr, fb_data);
    end else begin
      e = q.pop_front();
      if ({fb_addr, fb_data} !== e) begin
        n_fail++;
        $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h", fb_addr, fb_data, e[30:12], e[11:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic load_rom(input logic [11:0] key2);
    for (int i = 0; i < 8; i++) rom[i] = 12'h3A0 + 12'(i) * 12'h111;
    rom[2] = key2;
  endtask

  task automatic push_image(input int x0, input int y0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        int x, y;
        x = x0 + c;
        y = y0 + r;
`ifdef TRANSPARENT_KEY_EN
        if (rom[r*4+c] == 12'hF0F) continue;
`endif
        if (x < 640 && y < 480) q.push_back({19'(y * 640 + x), rom[r*4+c]});
      end
  endtask

  // called at a negedge after start was raised; counts busy/done cycles, optional mid-run restart attempt
  task automatic wait_copy(input int pulse_at, output int nb, output int nd, output int done_at);
    nb = 0;
    nd = 0;
    done_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        if (done) begin
          nd++;
          done_at = nb;
        end
        nb++;
      end else if (nb > 0) break;
      start = (i == pulse_at);
      if (i == pulse_at) begin
        dst_x = 10'd100;
        dst_y = 9'd100;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rom_addr, fb_we, fb_addr, fb_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got addr=%0d we=%b fa=%0d fd=%h busy=%b done=%b expected all 0", rom_addr, fb_we, fb_addr, fb_data, busy, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_copy(input string name, input int x0, input int y0, input logic [11:0] key2);
    int nb, nd, da;
    load_rom(key2);
    push_image(x0, y0);
    dst_x = 10'(x0);
    dst_y = 9'(y0);
    start = 1'b1;
    wait_copy(-1, nb, nd, da);
    n_checks++;
    if (nb !== 10 || nd !== 1 || da !== 9) begin
      n_fail++;
      $display("FAIL %s_timing busy=%0d done=%0d done_at=%0d expected 10 1 9", name, nb, nd, da);
    end
    n_checks++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes pending=%0d expected 0", name, q.size());
    end
    n_checks++;
    if (rom_addr !== 15'd0) begin
      n_fail++;
      $display("FAIL %s_rom_addr_idle got %0d expected 0", name, rom_addr);
    end
  endtask

  task automatic test_restart_ignored();
    int nb, nd, da;
    load_rom(12'h123);
    push_image(10, 5);
    dst_x = 10'd10;
    dst_y = 9'd5;
    start = 1'b1;
    wait_copy(3, nb, nd, da);
    n_checks++;
    if (nb !== 10 || nd !== 1 || da !== 9) begin
      n_fail++;
      $display("FAIL restart_timing busy=%0d done=%0d done_at=%0d expected 10 1 9", nb, nd, da);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL restart_queued busy=%b pending=%0d expected 0 0", busy, q.size());
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    load_rom(12'h456);
    q.push_back({19'd0, rom[0]});
    q.push_back({19'd1, rom[1]});
    dst_x = '0;
    dst_y = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || rom_addr !== 15'd0 || fb_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid we=%b busy=%b addr=%0d fa=%0d expected 0 0 0 0", fb_we, busy, rom_addr, fb_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) nb++;
    end
    n_checks++;
    if (nb !== 0 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_after busy_cycles=%0d pending=%0d expected 0 0", nb, q.size());
    end
  endtask

  task automatic test_back_to_back();
    load_rom(12'h789);
    push_image(5, 3);
    push_image(5, 3);
    dst_x = 10'd5;
    dst_y = 9'd3;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic eb, ed;
      @(negedge clk);
      eb = (i < 10) || (i >= 11 && i < 21);
      ed = (i == 9) || (i == 20);
      n_checks++;
      if (busy !== eb || done !== ed) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d busy=%b done=%b expected %b %b", i, busy, done, eb, ed);
      end
      if (i == 12) start = 1'b0;
    end
    n_checks++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_missing pending=%0d expected 0", q.size());
    end
  endtask

  initial begin
    load_rom(12'h3C2);
    test_reset();
    test_copy("basic", 0, 0, 12'h3C2);
    test_copy("offset", 100, 37, 12'hABC);
    test_copy("clip", 638, 479, 12'h3C2);
    test_copy("clip_x", 637, 10, 12'h3C2);
    test_copy("key", 20, 10, 12'hF0F);
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
